cache_host_if: RTL and testbench

CACHE_HOST_IF -- requirements
Module: cache_host_if

---
 rtl/cache_host_if.sv | 132 +++++++++++++
 tb/tb_cache_host_if.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_host_if.sv
// Host-facing front end of the cache controller: accepts one request at a time,
// pulses the op to the controller, waits (bounded) for completion, and holds the response.
package ctrl_types_pkg;
  typedef enum logic [1:0] {
    NOOP   = 2'd0,
    READ   = 2'd1,
    UPSERT = 2'd2,
    DELETE = 2'd3
  } operation_e;
endpackage

module cache_host_if
  import ctrl_types_pkg::*;
#(
  parameter int KEY_WIDTH = 32,
  parameter int VAL_WIDTH = 64,
  parameter int TIMEOUT   = 255  // must be >= 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [KEY_WIDTH-1:0] req_key,
  input  logic [VAL_WIDTH-1:0] req_val,
  output logic [1:0]           op_out,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic [VAL_WIDTH-1:0] val_out,
  input  logic                 ctrl_rdy,
  input  logic                 ctrl_succ,
  input  logic [VAL_WIDTH-1:0] rd_val,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_succ,
  output logic                 rsp_timeout,
  output logic [VAL_WIDTH-1:0] rsp_val,
  output logic                 busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    operation_e           op;
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } req_t;

  typedef struct packed {
    logic                 succ;
    logic                 timeout;
    logic [VAL_WIDTH-1:0] val;
  } rsp_t;

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  rsp_t             rsp_q, rsp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A NOOP is consumed here without disturbing the latched request.
        if (req_valid && (operation_e'(req_op) != NOOP)) begin
          req_d.op  = operation_e'(req_op);
          req_d.key = req_key;
          req_d.val = req_val;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion takes priority over a coincident timeout.
        if (ctrl_rdy) begin
          rsp_d.succ    = ctrl_succ;
          rsp_d.timeout = 1'b0;
          rsp_d.val     = (req_q.op == READ) ? rd_val : '0;
          state_d       = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_d.succ    = 1'b0;
          rsp_d.timeout = 1'b1;
          rsp_d.val     = '0;
          state_d       = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign op_out      = (state_q == ISSUE) ? req_q.op : NOOP;
  assign key_out     = req_q.key;
  assign val_out     = req_q.val;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_succ    = rsp_q.succ;
  assign rsp_timeout = rsp_q.timeout;
  assign rsp_val     = rsp_q.val;

endmodule

// File: tb/tb_cache_host_if.sv
// Bench for cache_host_if: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_cache_host_if;
  localparam int KW = 32;
  localparam int VW = 64;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'd0;
  logic [KW-1:0] req_key = '0;
  logic [VW-1:0] req_val = '0;
  logic [1:0]    op_out;
  logic [KW-1:0] key_out;
  logic [VW-1:0] val_out;
  logic          ctrl_rdy = 1'b0;
  logic          ctrl_succ = 1'b0;
  logic [VW-1:0] rd_val = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_succ;
  logic          rsp_timeout;
  logic [VW-1:0] rsp_val;
  logic          busy;

  cache_host_if #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_val(req_val),
    .op_out(op_out), .key_out(key_out), .val_out(val_out),
    .ctrl_rdy(ctrl_rdy), .ctrl_succ(ctrl_succ), .rd_val(rd_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_succ(rsp_succ),
    .rsp_timeout(rsp_timeout), .rsp_val(rsp_val), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level model: one pending request, age in cycles since accept.
  // Age 1 is the issue cycle; ages 2..TO+1 are the window in which a completion
  // is honoured; if none arrives by age TO+1 the request times out.
  bit            m_busy = 0, m_done = 0;
  int            m_age = 0;
  logic [1:0]    m_op = 0;
  logic [KW-1:0] m_key = 0;
  logic [VW-1:0] m_val = 0;
  logic          m_succ = 0, m_to = 0;
  logic [VW-1:0] m_rval = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_age = 0; m_op = 0; m_key = 0; m_val = 0;
      m_succ = 0; m_to = 0; m_rval = 0;
    end else if (!m_busy) begin
      if (req_valid && req_op != 2'd0) begin
        m_busy = 1; m_age = 1; m_op = req_op; m_key = req_key; m_val = req_val;
      end
    end else if (m_done) begin
      if (rsp_ready) begin m_busy = 0; m_done = 0; end
    end else if (m_age >= 2 && ctrl_rdy) begin
      m_done = 1; m_succ = ctrl_succ; m_to = 0;
      m_rval = (m_op == 2'd1) ? rd_val : '0;
    end else if (m_age == TO + 1) begin
      m_done = 1; m_succ = 0; m_to = 1; m_rval = '0;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready, !m_busy);
    chk("busy", busy, m_busy);
    chk("op_out", op_out, (m_busy && !m_done && m_age == 1) ? m_op : 2'd0);
    chk("key_out", key_out, m_key);
    chk("val_out", val_out, m_val);
    chk("rsp_valid", rsp_valid, m_done);
    if (m_done || !rst_n) begin
      chk("rsp_succ", rsp_succ, m_done ? m_succ : 1'b0);
      chk("rsp_timeout", rsp_timeout, m_done ? m_to : 1'b0);
      chk("rsp_val", rsp_val, m_done ? m_rval : '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_wait;
    bit got;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_op_out", op_out, 2'd0);
    chk("rst_key_out", key_out, '0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    rst_n = 1'b1;
    tick();

    // READ hit: op pulse one cycle after accept, response two cycles later
    req_valid = 1; req_op = 2'd1; req_key = 32'h1234;
    tick();
    req_valid = 0; req_op = 2'd0;
    chk("rd_op_out_issue", op_out, 2'd1);
    chk("rd_key_out", key_out, 32'h1234);
    tick();
    chk("rd_op_out_wait", op_out, 2'd0);
    ctrl_rdy = 1; ctrl_succ = 1; rd_val = 64'hCAFE;
    tick();
    ctrl_rdy = 0; ctrl_succ = 0; rd_val = 0;
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_succ", rsp_succ, 1'b1);
    chk("rd_rsp_val", rsp_val, 64'hCAFE);
    chk("rd_rsp_timeout", rsp_timeout, 1'b0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("rd_back_idle", req_ready, 1'b1);

    // UPSERT failing, then a stalled response with a waiting request
    req_valid = 1; req_op = 2'd2; req_key = 32'h55; req_val = 64'hBEEF;
    tick();
    req_valid = 0; req_op = 2'd0; req_val = 0;
    chk("up_val_out", val_out, 64'hBEEF);
    tick();
    tick();
    ctrl_rdy = 1; ctrl_succ = 0; rd_val = 64'h1111;
    tick();
    ctrl_rdy = 0; rd_val = 0;
    chk("up_rsp_succ", rsp_succ, 1'b0);
    chk("up_rsp_val", rsp_val, 64'h0);
    req_valid = 1; req_op = 2'd3; req_key = 32'h77; req_val = 64'h4242;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rsp_valid", rsp_valid, 1'b1);
      chk("stall_rsp_succ", rsp_succ, 1'b0);
      chk("stall_req_ready", req_ready, 1'b0);
      chk("stall_busy", busy, 1'b1);
      chk("stall_val_out", val_out, 64'hBEEF);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("stall_release_ready", req_ready, 1'b1);

    // DELETE accepted from the waiting request; no completion -> timeout
    tick();
    req_valid = 0; req_op = 2'd0;
    chk("del_op_out", op_out, 2'd3);
    chk("del_key_out", key_out, 32'h77);
    n_wait = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (rsp_valid) got = 1;
      else n_wait++;
    end
    chk("to_seen", got, 1'b1);
    chk("to_wait_cycles", n_wait, TO);
    chk("to_rsp_timeout", rsp_timeout, 1'b1);
    chk("to_rsp_succ", rsp_succ, 1'b0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // Reset while waiting; stray completion afterwards is ignored
    req_valid = 1; req_op = 2'd1; req_key = 32'hABCD;
    tick();
    req_valid = 0; req_op = 2'd0;
    tick();
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_key_out", key_out, '0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    tick();
    rst_n = 1;
    ctrl_rdy = 1; ctrl_succ = 1; rd_val = 64'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_rsp_valid", rsp_valid, 1'b0);
      chk("stray_op_out", op_out, 2'd0);
    end
    ctrl_rdy = 0; ctrl_succ = 0; rd_val = 0;

    // NOOP requests are swallowed
    req_valid = 1; req_op = 2'd0; req_key = 32'h3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("noop_busy", busy, 1'b0);
      chk("noop_op_out", op_out, 2'd0);
      chk("noop_rsp_valid", rsp_valid, 1'b0);
    end
    req_valid = 0;

    // Randomized traffic with occasional asynchronous reset
    for (int c = 0; c < 4000; c++) begin
      req_valid = ($urandom_range(1, 0) == 1);
      req_op    = 2'($urandom_range(3, 0));
      req_key   = $urandom;
      req_val   = {$urandom, $urandom};
      ctrl_rdy  = ($urandom_range(3, 0) == 0);
      ctrl_succ = ($urandom_range(1, 0) == 1);
      rd_val    = {$urandom, $urandom};
      rsp_ready = ($urandom_range(1, 0) == 1);
      if ($urandom_range(199, 0) == 0) begin
        #2 rst_n = 0;
        tick();
        tick();
        #2 rst_n = 1;
      end
      tick();
    end

    req_valid = 0; ctrl_rdy = 0; rsp_ready = 0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
